alu_seq_exec: RTL and testbench



---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_comb.sv | 42 ++++
 rtl/alu_seq_exec.sv | 126 ++++++++++++
 tb/tb_alu_seq_exec.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU.
//   - 4-bit operation codes (the same values ALU control drives)
//   - State encoding of the sequential execute unit
//   - is_shift_op(): true for the ops that take the serial shift path
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Purely combinational single-cycle ALU operations.
// Ports:
//   op  in  4     operation code
//   a   in  XLEN  operand A
//   b   in  XLEN  operand B
//   y   out XLEN  result; 0 for shift codes and unknown codes
// -----------------------------------------------------------------------------
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    y = '0;
    case (op)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_XOR:  y = a ^ b;
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
      ALU_NOR:  y = ~(a | b);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// -----------------------------------------------------------------------------
// alu_seq_exec
// EX-stage execute unit. Logic/arithmetic ops finish in one cycle; shifts
// iterate one bit position per cycle through a working register.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready high only in IDLE)
//   ALUctrl           operation code (sampled only on accept)
//   op_a, op_b        operands; shift amount is op_b[SHW-1:0]
//   out_valid/out_ready output handshake
//   result, zero      registered result and result==0 flag
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_valid/ALUctrl/op_a/op_b matter only on the accepting edge;
// result/zero are stable for as long as out_valid is high and out_ready low.
// -----------------------------------------------------------------------------
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  state_t          state;
  state_t          state_next;
  logic [3:0]      op_q;
  logic [XLEN-1:0] work_q;
  logic [XLEN-1:0] work_step;
  logic [XLEN-1:0] comb_y;
  logic [XLEN-1:0] imm_y;
  logic [SHW-1:0]  cnt_q;
  logic [SHW-1:0]  shamt;
  logic            accept;
  logic            start_shift;
  logic            last_step;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .op (ALUctrl),
    .a  (op_a),
    .b  (op_b),
    .y  (comb_y)
  );

  assign shamt       = op_b[SHW-1:0];
  assign accept      = (state == ST_IDLE) && in_valid;
  assign start_shift = is_shift_op(ALUctrl) && (shamt != '0);
  assign last_step   = (state == ST_SHIFT) && (cnt_q == SHW'(1));
  // A shift by zero is just op_a, so it rides the single-cycle path.
  assign imm_y       = is_shift_op(ALUctrl) ? op_a : comb_y;

  // One-position shift of the working register, direction from the captured op.
  always_comb begin
    work_step = work_q >> 1;
    case (op_q)
      ALU_SLL: work_step = work_q << 1;
      ALU_SRA: work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: work_step = work_q >> 1;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (in_valid) state_next = start_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (last_step) state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Datapath: operation capture, shift iteration, result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= ALUctrl;
        if (start_shift) begin
          work_q <= op_a;
          cnt_q  <= shamt;
        end else begin
          result <= imm_y;
          zero   <= (imm_y == '0);
        end
      end
      if (state == ST_SHIFT) begin
        work_q <= work_step;
        cnt_q  <= cnt_q - SHW'(1);
        if (last_step) begin
          result <= work_step;
          zero   <= (work_step == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;
  import alu_pkg::*;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      ALUctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  always #5 clk = ~clk;

  alu_seq_exec #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUctrl   (ALUctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] sb_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_ADD:  return a + b;
      ALU_XOR:  return a ^ b;
      ALU_SUB:  return a - b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_NOR:  return ~(a | b);
      ALU_SLL:  return a << s;
      ALU_SRL:  return a >> s;
      ALU_SRA:  return 32'($signed(a) >>> s);
      default:  return 32'd0;
    endcase
  endfunction

  // Edges from the accepting edge (counted as 1) until out_valid is visible.
  function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
    if ((op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) && b[4:0] != 5'd0)
      return 1 + int'(b[4:0]);
    return 1;
  endfunction

  // ---------------- scoreboard compare ----------------
  // Checks every consumed result against the model's queued expectation.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_spurious_out_valid", 32'd1, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_result", result, sb_e);
        chk("sb_zero", {31'b0, zero}, {31'b0, (sb_e == 32'd0)});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit use_lit, input logic [31:0] lit,
                        input string name);
    int n;
    logic [31:0] held_r;
    logic held_z;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk({name, "_in_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    ALUctrl   = op;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(model_result(op, a, b));
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        // Inputs after the accept edge must have no effect.
        in_valid = 1'b0;
        ALUctrl  = 4'($urandom_range(0, 15));
        op_a     = $urandom;
        op_b     = $urandom;
      end
    end while (!out_valid && n < XLEN + 4);
    chk({name, "_latency"}, n, model_latency(op, b));
    if (!out_valid) begin
      void'(exp_q.pop_back());
      out_ready = 1'b1;
      return;
    end
    if (use_lit) chk({name, "_lit"}, result, lit);
    held_r = result;
    held_z = zero;
    for (int i = 0; i < hold; i++) begin
      // A competing request while DONE must not be accepted.
      in_valid = 1'b1;
      ALUctrl  = ALU_ADD;
      op_a     = $urandom;
      op_b     = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      chk({name, "_hold_result"}, result, held_r);
      chk({name, "_hold_zero"}, {31'b0, zero}, {31'b0, held_z});
      chk({name, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_pulse"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic reset_abort_test();
    bit seen;
    in_valid  = 1'b1;
    ALUctrl   = ALU_SRL;
    op_a      = 32'hFFFF_0000;
    op_b      = 32'd10;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", {31'b0, zero}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", {31'b0, seen}, 32'd0);
    // rst and in_valid together: nothing accepted.
    rst      = 1'b1;
    in_valid = 1'b1;
    ALUctrl  = ALU_ADD;
    op_a     = 32'd1;
    op_b     = 32'd2;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_wins_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_wins_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_wins_result", result, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [3:0] codes [11] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SUB,
                             ALU_SLT, ALU_SLTU, ALU_SRL, ALU_NOR, ALU_SRA};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ALUctrl   = '0;
    op_a      = '0;
    op_b      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'b0, zero}, 32'd0);

    // Pin the model with hand-computed values.
    chk("pin_model_sra", model_result(ALU_SRA, 32'h8000_0000, 32'd4), 32'hF800_0000);
    chk("pin_model_slt", model_result(ALU_SLT, 32'hFFFF_FFFF, 32'd1), 32'd1);
    chk("pin_model_nor", model_result(ALU_NOR, 32'h0F0F_0000, 32'h00F0_00FF), 32'hF000_FF00);
    chk("pin_model_lat", model_latency(ALU_SLL, 32'd31), 32'd32);

    run_op(ALU_ADD,  32'h0000_0005, 32'hFFFF_FFFB, 0, 1, 32'h0000_0000, "add_wrap");
    run_op(ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 32'h0000_0001, "slt");
    run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 32'h0000_0000, "sltu");
    run_op(ALU_SRA,  32'h8000_0000, 32'h0000_0004, 0, 1, 32'hF800_0000, "sra4");
    run_op(ALU_SRL,  32'h8000_0000, 32'h0000_0004, 0, 1, 32'h0800_0000, "srl4");
    run_op(ALU_SLL,  32'h0000_0001, 32'h0000_001F, 0, 1, 32'h8000_0000, "sll31");
    run_op(ALU_SLL,  32'h1234_5678, 32'h0000_0020, 0, 1, 32'h1234_5678, "sll_zero_amt");
    run_op(ALU_ADD,  32'h0000_0010, 32'h0000_0020, 3, 1, 32'h0000_0030, "add_hold");
    run_op(ALU_SUB,  32'h0000_0003, 32'h0000_0005, 0, 1, 32'hFFFF_FFFE, "sub_neg");
    run_op(ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 0, 1, 32'h00F0_1200, "and");
    run_op(ALU_OR,   32'hF000_0001, 32'h0000_0010, 0, 1, 32'hF000_0011, "or");
    run_op(ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 0, 1, 32'h5555_5555, "xor");
    run_op(ALU_NOR,  32'h0F0F_0000, 32'h00F0_00FF, 0, 1, 32'hF000_FF00, "nor");
    run_op(ALU_SRA,  32'h4000_0000, 32'h0000_001F, 0, 1, 32'h0000_0000, "sra31_pos");
    run_op(ALU_SRA,  32'hF000_0000, 32'h0000_001F, 1, 1, 32'hFFFF_FFFF, "sra31_neg");
    run_op(4'b1111,  32'h1234_5678, 32'h1111_1111, 0, 1, 32'h0000_0000, "unknown_f");

    reset_abort_test();
    run_op(4'b0101,  32'hDEAD_BEEF, 32'h0000_0001, 0, 1, 32'h0000_0000, "unknown_5");

    for (int i = 0; i < 8; i++) begin
      run_op(codes[$urandom_range(0, 10)], $urandom, $urandom, int'($urandom_range(0, 2)),
             1'b0, 32'd0, "rand");
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
